// File: rtl/rf_pkg.sv
// Shared types and default sizing for the parameterised register file.
package rf_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned NREG_DEF = 32;
    localparam int unsigned NRD_DEF  = 2;

endpackage

// File: rtl/rf_clear_seq.sv
// Bulk-clear sequencer: walks every register index once, one per cycle.
module rf_clear_seq
    import rf_pkg::*;
#(
    parameter  int unsigned NREG = NREG_DEF,
    localparam int unsigned AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_req,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    clr_state_e    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                // clr_req is deliberately not looked at here: no restart mid-sequence
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == AW'(NREG - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy     = (state_q == CLEAR);
    assign clr_we   = busy;
    assign clr_addr = cnt_q;

endmodule

// File: rtl/reg_file_param.sv
// Multi-port register file with byte-enable writes, write-to-read bypass,
// a per-register pending scoreboard and a sequenced bulk clear.
module reg_file_param
    import rf_pkg::*;
#(
    parameter  int unsigned XLEN    = XLEN_DEF,
    parameter  int unsigned NREG    = NREG_DEF,
    parameter  int unsigned NRD     = NRD_DEF,
    parameter  bit          ZERO_R0 = 1'b1,
    parameter  bit          BYPASS  = 1'b1,
    localparam int unsigned AW      = $clog2(NREG),
    localparam int unsigned NB      = XLEN / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] rs,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]    pending,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [NB-1:0]     wbe,
    input  logic              sb_set,
    input  logic [AW-1:0]     sb_addr,
    input  logic              clr_req,
    output logic              clr_busy
);

    logic            busy, clr_we;
    logic [AW-1:0]   clr_addr;
    logic            wr_acc, wr_r0, clr_start;
    logic [XLEN-1:0] wr_merged;
    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] sb_q, sb_d;

    rf_clear_seq #(.NREG(NREG)) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign clr_busy  = busy;
    assign wr_acc    = we && !busy;
    assign wr_r0     = ZERO_R0 && (waddr == '0);
    assign clr_start = clr_req && !busy;

    always_comb begin
        wr_merged = regs_q[waddr];
        for (int unsigned b = 0; b < NB; b++) begin
            if (wbe[b]) begin
                wr_merged[b*8 +: 8] = wdata[b*8 +: 8];
            end
        end
    end

    always_comb begin
        regs_d = regs_q;
        if (clr_we) begin
            regs_d[clr_addr] = '0;
        end else if (wr_acc && !wr_r0) begin
            regs_d[waddr] = wr_merged;
        end
    end

    // Set is applied after clear so a same-address set wins; clear entry overrides both.
    always_comb begin
        sb_d = sb_q;
        if (clr_start) begin
            sb_d = '0;
        end else if (!busy) begin
            if (wr_acc) sb_d[waddr]   = 1'b0;
            if (sb_set) sb_d[sb_addr] = 1'b1;
        end
        if (ZERO_R0) sb_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            sb_q <= '0;
        end else begin
            regs_q <= regs_d;
            sb_q   <= sb_d;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] addr;
        logic          is_r0, hit;
        assign addr  = rs[i*AW +: AW];
        assign is_r0 = ZERO_R0 && (addr == '0);
        assign hit   = BYPASS && wr_acc && (addr == waddr);
        assign rdata[i*XLEN +: XLEN] = is_r0 ? '0 : (hit ? wr_merged : regs_q[addr]);
        assign pending[i] = sb_q[addr];
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param (default parameters) with an expectation queue.
module tb_reg_file_param;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs0, rs1;
    logic [9:0]  rs;
    logic [63:0] rdata;
    logic [1:0]  pending;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  wbe;
    logic        sb_set;
    logic [4:0]  sb_addr;
    logic        clr_req;
    logic        clr_busy;

    assign rs = {rs1, rs0};

    reg_file_param #(
        .XLEN(32), .NREG(32), .NRD(2), .ZERO_R0(1'b1), .BYPASS(1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rs       (rs),
        .rdata    (rdata),
        .pending  (pending),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .wbe      (wbe),
        .sb_set   (sb_set),
        .sb_addr  (sb_addr),
        .clr_req  (clr_req),
        .clr_busy (clr_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        q.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL queue_empty observed=%h expected=<none>", obs);
        end else begin
            e = q.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we = 1'b0; waddr = '0; wdata = '0; wbe = '0;
        sb_set = 1'b0; sb_addr = '0; clr_req = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        we = 1'b1; waddr = a; wdata = d; wbe = be;
        tick();
        we = 1'b0;
    endtask

    logic [31:0] model [32];
    int          busy_n;

    initial begin
        rst = 1'b1; rs0 = '0; rs1 = '0;
        idle_inputs();
        #3;
        rs0 = 5'd5; rs1 = 5'd17;
        #1;
        expect_val("rst_busy", 32'd0);      check({31'd0, clr_busy});
        expect_val("rst_pending", 32'd0);   check({30'd0, pending});
        expect_val("rst_rdata0", 32'd0);    check(rdata[31:0]);
        expect_val("rst_rdata1", 32'd0);    check(rdata[63:32]);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Test 1: byte-enable merge
        wr(5'd5, 32'hDEADBEEF, 4'hF);
        wr(5'd5, 32'h00000011, 4'h1);
        rs0 = 5'd5;
        expect_val("t1_merge", 32'hDEADBE11);
        @(negedge clk); check(rdata[31:0]);

        // Test 2: r0 hardwired to zero, scoreboard bit 0 never set
        wr(5'd0, 32'h00001234, 4'hF);
        rs0 = 5'd0; rs1 = 5'd0;
        expect_val("t2_r0_rd0", 32'd0);
        expect_val("t2_r0_rd1", 32'd0);
        @(negedge clk); check(rdata[31:0]); check(rdata[63:32]);
        tick();
        sb_set = 1'b1; sb_addr = 5'd0;
        tick();
        sb_set = 1'b0;
        expect_val("t2_r0_pending", 32'd0);
        @(negedge clk); check({31'd0, pending[0]});

        // Test 3: same-cycle bypass on both ports, then committed value
        tick();
        wr(5'd3, 32'hAAAA0000, 4'hF);
        we = 1'b1; waddr = 5'd3; wdata = 32'h00005555; wbe = 4'h3;
        rs0 = 5'd3; rs1 = 5'd3;
        expect_val("t3_bypass0", 32'hAAAA5555);
        expect_val("t3_bypass1", 32'hAAAA5555);
        @(negedge clk); check(rdata[31:0]); check(rdata[63:32]);
        tick();
        we = 1'b0;
        expect_val("t3_commit", 32'hAAAA5555);
        @(negedge clk); check(rdata[31:0]);

        // Test 4: scoreboard set / set-wins / write-clear, no same-cycle bypass
        tick();
        sb_set = 1'b1; sb_addr = 5'd7; rs0 = 5'd7;
        expect_val("t4_no_bypass_set", 32'd0);
        @(negedge clk); check({31'd0, pending[0]});
        tick();
        sb_set = 1'b0;
        expect_val("t4_set", 32'd1);
        @(negedge clk); check({31'd0, pending[0]});
        tick();
        we = 1'b1; waddr = 5'd7; wdata = 32'h77; wbe = 4'hF;
        sb_set = 1'b1; sb_addr = 5'd7;
        tick();
        idle_inputs();
        expect_val("t4_set_wins", 32'd1);
        @(negedge clk); check({31'd0, pending[0]});
        tick();
        we = 1'b1; waddr = 5'd7; wdata = 32'h78; wbe = 4'hF;
        expect_val("t4_no_bypass_clr", 32'd1);
        @(negedge clk); check({31'd0, pending[0]});
        tick();
        we = 1'b0;
        expect_val("t4_cleared", 32'd0);
        @(negedge clk); check({31'd0, pending[0]});

        // Test 5: fill, bulk clear, dropped write/set/clr_req during clear
        tick();
        for (int i = 1; i < 32; i++) begin
            model[i] = 32'h1000_0000 + (32'(i) << 8) + 32'(i);
            wr(5'(i), model[i], 4'hF);
        end
        sb_set = 1'b1; sb_addr = 5'd9;
        tick();
        sb_set = 1'b0;
        rs1 = 5'd9;
        expect_val("t5_pend9_pre", 32'd1);
        @(negedge clk); check({31'd0, pending[1]});
        tick();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        busy_n = 0;
        for (int c = 0; c < 100; c++) begin
            we = (c == 5); waddr = 5'd2; wdata = 32'h0000FFFF; wbe = 4'hF;
            sb_set = (c == 5); sb_addr = 5'd12;
            clr_req = (c == 10);
            if (c == 3) begin
                rs0 = 5'd1; rs1 = 5'd20;
                expect_val("t5_mid_cleared", 32'd0);
                expect_val("t5_mid_intact", model[20]);
            end
            @(negedge clk);
            if (!clr_busy) break;
            busy_n++;
            if (c == 3) begin
                check(rdata[31:0]); check(rdata[63:32]);
            end
            tick();
        end
        idle_inputs();
        expect_val("t5_busy_cycles", 32'd32);
        check(32'(busy_n));
        rs0 = 5'd9; rs1 = 5'd12;
        expect_val("t5_pend9_clr", 32'd0);
        expect_val("t5_pend12_drop", 32'd0);
        #1; check({31'd0, pending[0]}); check({31'd0, pending[1]});
        tick();
        for (int r = 0; r < 32; r++) begin
            rs0 = 5'(r); rs1 = 5'(31 - r);
            expect_val($sformatf("t5_zero_r%0d", r), 32'd0);
            @(negedge clk); check(rdata[31:0] | rdata[63:32]);
            tick();
        end

        // Test 6: reset mid-clear aborts and does not resume
        wr(5'd4, 32'h00000044, 4'hF);
        wr(5'd30, 32'h00003030, 4'hF);
        sb_set = 1'b1; sb_addr = 5'd15;
        tick();
        sb_set = 1'b0;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        rs0 = 5'd30; rs1 = 5'd15;
        expect_val("t6_busy_pre", 32'd1);
        #1; check({31'd0, clr_busy});
        rst = 1'b1;
        #2;
        expect_val("t6_busy_rst", 32'd0);
        expect_val("t6_r30_rst", 32'd0);
        expect_val("t6_pend_rst", 32'd0);
        check({31'd0, clr_busy}); check(rdata[31:0]); check({30'd0, pending});
        @(negedge clk);
        rst = 1'b0;
        tick();
        wr(5'd30, 32'h00000077, 4'hF);
        busy_n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (clr_busy) busy_n++;
            tick();
        end
        expect_val("t6_no_resume", 32'd0);
        check(32'(busy_n));
        expect_val("t6_r30_kept", 32'h00000077);
        @(negedge clk); check(rdata[31:0]);

        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_leftover observed=%0d expected=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_param.md
REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning data width in bits (multiple of 8).
REQ-002 The block SHALL have parameter NREG, default 32, meaning register count (power of two, 2..64).
REQ-003 The block SHALL have parameter NRD, default 2, meaning number of read ports (1..4).
REQ-004 The block SHALL have parameter ZERO_R0, default 1, meaning register 0 reads zero and ignores writes.
REQ-005 The block SHALL have parameter BYPASS, default 1, meaning same-cycle write-to-read forwarding is enabled.
REQ-006 The block SHALL have port clk, input, width 1, the single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port rst, input, width 1; reset is asynchronous and active-high.
REQ-008 The block SHALL have port rs, input, width NRD*AW (AW=log2 NREG), the read addresses; port i is at slice i.
REQ-009 The block SHALL have port rdata, output, width NRD*XLEN, the read data per port.
REQ-010 The block SHALL have port pending, output, width NRD, meaning the scoreboard bit of rs[i] is set.
REQ-011 The block SHALL have port we, input, width 1, the write enable.
REQ-012 The block SHALL have port waddr, input, width AW, the write address.
REQ-013 The block SHALL have port wdata, input, width XLEN, the write data.
REQ-014 The block SHALL have port wbe, input, width XLEN/8, the byte enables for the write.
REQ-015 The block SHALL have port sb_set, input, width 1; when high, it marks sb_addr as pending.
REQ-016 The block SHALL have port sb_addr, input, width AW, the scoreboard set address.
REQ-017 The block SHALL have port clr_req, input, width 1; it requests a clear of all registers.
REQ-018 The block SHALL have port clr_busy, output, width 1; it is high while the clear sequence runs.

Function
REQ-019 Reads SHALL be combinational: rdata[i] = reg[rs[i]], or 0 when ZERO_R0=1 and rs[i]=0.
REQ-020 A write SHALL update, at the clock edge, only the bytes of reg[waddr] whose wbe bit is set, and only when we=1 and clr_busy=0.
REQ-021 When BYPASS=1, we=1, clr_busy=0 and rs[i]=waddr (non-zero when ZERO_R0=1), rdata[i] SHALL equal the old value merged bytewise with wdata under wbe, in the same cycle.
REQ-022 When BYPASS=0, rdata SHALL return the pre-write value until the following cycle.
REQ-023 The scoreboard SHALL hold one bit per register: sb_set sets bit sb_addr, and an accepted write clears bit waddr, both at the clock edge.
REQ-024 When sb_set and an accepted write target the same address in the same cycle, set SHALL win.
REQ-025 When ZERO_R0=1, scoreboard bit 0 SHALL never set.
REQ-026 pending[i] SHALL be combinational from the registered scoreboard, with no bypass of same-cycle set/clear.
REQ-027 The clear FSM SHALL have two states: IDLE and CLEAR.
REQ-028 In IDLE with clr_req=1, the FSM SHALL move to CLEAR, zero the counter, and clear all scoreboard bits at that edge.
REQ-029 In CLEAR, the FSM SHALL write reg[cnt]=0 each cycle and increment cnt; it SHALL return to IDLE after cnt=NREG-1, so a clear takes NREG cycles.
REQ-030 clr_busy SHALL equal (state==CLEAR).
REQ-031 In CLEAR, external writes and sb_set SHALL be ignored, and clr_req SHALL be ignored (no restart).
REQ-032 Reads during CLEAR SHALL return current contents: already-cleared registers read 0.

Reset
REQ-033 Asserting rst SHALL immediately set all registers to 0, clear all scoreboard bits, set FSM=IDLE and cnt=0, giving clr_busy=0 and pending=0.
REQ-034 Reset mid-CLEAR SHALL abort the sequence; no clear SHALL resume after release.

Structure
REQ-035 Package rf_pkg SHALL hold the FSM state enumeration and the default parameter constants (XLEN, NREG, NRD).
REQ-036 The clear FSM and counter SHALL be one sub-module, rf_clear_seq, with outputs busy, clr_we and clr_addr.
REQ-037 Read ports SHALL be built with a generate loop over NRD.

Verification
REQ-038 Test 1: write r5=0xDEADBEEF with wbe=0xF, then write wbe=0x1 wdata=0x11 -> rdata of r5 = 0xDEADBE11.
REQ-039 Test 2: write r0=0x1234, then read r0 -> 0; sb_set r0 -> pending=0.
REQ-040 Test 3 (BYPASS=1): reg r3=0xAAAA0000; in the same cycle, write r3=0x5555 with wbe=0x3 and rs0=3 -> rdata0=0xAAAA5555 in that cycle.
REQ-041 Test 4: sb_set r7; next cycle pending[0]=1 (rs0=7); write r7 with sb_set r7 in the same cycle -> pending stays 1; write r7 alone -> pending=0.
REQ-042 Test 5: fill all registers, then pulse clr_req -> clr_busy high for exactly 32 cycles, write attempted mid-clear is dropped, all reads then return 0.
REQ-043 Test 6: assert rst at clear cycle 10 -> all registers 0, clr_busy=0, and no further clear activity after release.
